// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: accumulates credit, dispenses one item, and pays change as 4/2/1-ruble coins.
// Optional refund on cancel while collecting is compiled in with the VEND_CANCEL_EN macro.
module vend_ctrl #(
    parameter int PRICE    = 5,
    parameter int COIN_A   = 1,
    parameter int COIN_B   = 2,
    parameter int COIN_C   = 5,
    parameter int CREDIT_W = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                vend,
    output logic                give_1_ruble_back,
    output logic                give_2_rubles_back,
    output logic                give_4_rubles_back,
    output logic [CREDIT_W-1:0] summ,
    output logic                busy,
    output logic                coin_reject
);

    localparam int COIN_AB  = (COIN_A > COIN_B) ? COIN_A : COIN_B;
    localparam int COIN_MAX = (COIN_AB > COIN_C) ? COIN_AB : COIN_C;
    localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

    // Credit never exceeds PRICE-1 before a coin, so this bound rules out wrap-around.
    generate
        if (PRICE < 1 || (PRICE - 1 + COIN_MAX) >= (1 << CREDIT_W)) begin : g_bad_params
            $error("vend_ctrl: CREDIT_W too narrow for PRICE and coin values");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] summ_reg, summ_next;
    logic [CREDIT_W-1:0] rem_reg, rem_next;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          give_amt;
    logic                cancel_req;

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel && (state_reg == COLLECT);
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_req    = 1'b0;
`endif

    always_comb begin
        case (coin)
            2'b01:   coin_val = CREDIT_W'(COIN_A);
            2'b10:   coin_val = CREDIT_W'(COIN_B);
            2'b11:   coin_val = CREDIT_W'(COIN_C);
            default: coin_val = '0;
        endcase
    end

    assign credit = summ_reg + coin_val;

    // Largest returnable coin that fits the remaining change.
    always_comb begin
        if (int'(rem_reg) >= 4)      give_amt = 3'd4;
        else if (int'(rem_reg) >= 2) give_amt = 3'd2;
        else                         give_amt = 3'd1;
    end

    always_comb begin
        state_next = state_reg;
        summ_next  = summ_reg;
        rem_next   = rem_reg;
        case (state_reg)
            IDLE, COLLECT: begin
                if (cancel_req) begin
                    rem_next   = credit;
                    summ_next  = '0;
                    state_next = CHANGE;
                end else if (coin != 2'b00) begin
                    summ_next  = credit;
                    state_next = (credit >= PRICE_W) ? VEND : COLLECT;
                end
            end
            VEND: begin
                rem_next   = summ_reg - PRICE_W;
                summ_next  = '0;
                state_next = (summ_reg != PRICE_W) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rem_next = rem_reg - CREDIT_W'(give_amt);
                if (rem_reg == CREDIT_W'(give_amt)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_reg <= IDLE;
            summ_reg  <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            summ_reg  <= summ_next;
            rem_reg   <= rem_next;
        end
    end

    assign vend               = (state_reg == VEND);
    assign busy               = (state_reg == VEND) || (state_reg == CHANGE);
    assign give_4_rubles_back = (state_reg == CHANGE) && (give_amt == 3'd4);
    assign give_2_rubles_back = (state_reg == CHANGE) && (give_amt == 3'd2);
    assign give_1_ruble_back  = (state_reg == CHANGE) && (give_amt == 3'd1);
    assign coin_reject        = busy && (coin != 2'b00);
    assign summ               = summ_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// Table-driven bench for vend_ctrl (PRICE=5, coins 1/2/5) with a scoreboard queue of expected post-edge outputs.
module tb_vend_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       vend, give_1_ruble_back, give_2_rubles_back, give_4_rubles_back;
    logic [3:0] summ;
    logic       busy, coin_reject;

    int checks = 0;
    int errors = 0;

    vend_ctrl dut (
        .CLK                (CLK),
        .reset              (reset),
        .coin               (coin),
        .cancel             (cancel),
        .vend               (vend),
        .give_1_ruble_back  (give_1_ruble_back),
        .give_2_rubles_back (give_2_rubles_back),
        .give_4_rubles_back (give_4_rubles_back),
        .summ               (summ),
        .busy               (busy),
        .coin_reject        (coin_reject)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] coin;
        logic       cancel;
        logic       rst_n;
        logic       rej;   // coin_reject before the edge
        logic       vend;  // remaining fields: after the edge
        logic       g1;
        logic       g2;
        logic       g4;
        logic [3:0] summ;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic add(input logic [1:0] c, input logic can, input logic r, input logic rej,
                       input logic v, input logic g1, input logic g2, input logic g4,
                       input logic [3:0] s, input logic b);
        vec_t t;
        t.coin = c; t.cancel = can; t.rst_n = r; t.rej = rej; t.vend = v;
        t.g1 = g1; t.g2 = g2; t.g4 = g4; t.summ = s; t.busy = b;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            @(negedge CLK);
            coin = vecs[i].coin; cancel = vecs[i].cancel; reset = vecs[i].rst_n;
            exp_q.push_back(vecs[i]);
            #1;
            check("coin_reject", i, {7'd0, coin_reject}, {7'd0, vecs[i].rej});
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            check("vend", i, {7'd0, vend}, {7'd0, e.vend});
            check("give", i, {5'd0, give_4_rubles_back, give_2_rubles_back, give_1_ruble_back},
                  {5'd0, e.g4, e.g2, e.g1});
            check("summ", i, {4'd0, summ}, {4'd0, e.summ});
            check("busy", i, {7'd0, busy}, {7'd0, e.busy});
            $display("vec %0d: coin=%0d cancel=%0b reset=%0b -> vend=%0b give=%b summ=%0d busy=%0b",
                     i, vecs[i].coin, vecs[i].cancel, vecs[i].rst_n, vend,
                     {give_4_rubles_back, give_2_rubles_back, give_1_ruble_back}, summ, busy);
        end
    endtask

    int vend_cnt, give_cnt, g2_cnt, cyc;

    initial begin
        //   coin  can rst rej vend g1 g2 g4 summ busy
        add(2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);   // reset
        add(2'b11, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);   // coin under reset ignored
        add(2'b00, 1, 1, 0, 0, 0, 0, 0, 4'd0, 0);   // cancel in IDLE ignored
        // 1,2,2 -> exact price
        add(2'b01, 0, 1, 0, 0, 0, 0, 0, 4'd1, 0);
        add(2'b10, 0, 1, 0, 0, 0, 0, 0, 4'd3, 0);
        add(2'b10, 0, 1, 0, 1, 0, 0, 0, 4'd5, 1);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
        // 2,5 -> change 2
        add(2'b10, 0, 1, 0, 0, 0, 0, 0, 4'd2, 0);
        add(2'b11, 0, 1, 0, 1, 0, 0, 0, 4'd7, 1);
        add(2'b00, 0, 1, 0, 0, 0, 1, 0, 4'd0, 1);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
        // 1,1,1,5 -> change 3, coins rejected in VEND and CHANGE
        add(2'b01, 0, 1, 0, 0, 0, 0, 0, 4'd1, 0);
        add(2'b01, 0, 1, 0, 0, 0, 0, 0, 4'd2, 0);
        add(2'b01, 0, 1, 0, 0, 0, 0, 0, 4'd3, 0);
        add(2'b11, 0, 1, 0, 1, 0, 0, 0, 4'd8, 1);
        add(2'b01, 0, 1, 1, 0, 0, 1, 0, 4'd0, 1);
        add(2'b10, 0, 1, 1, 0, 1, 0, 0, 4'd0, 1);
        add(2'b11, 0, 1, 1, 0, 0, 0, 0, 4'd0, 0);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
        // 2,2,5 -> change 4
        add(2'b10, 0, 1, 0, 0, 0, 0, 0, 4'd2, 0);
        add(2'b10, 0, 1, 0, 0, 0, 0, 0, 4'd4, 0);
        add(2'b11, 0, 1, 0, 1, 0, 0, 0, 4'd9, 1);
        add(2'b00, 0, 1, 0, 0, 0, 0, 1, 4'd0, 1);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
        // 1,2 then cancel
        add(2'b01, 0, 1, 0, 0, 0, 0, 0, 4'd1, 0);
        add(2'b10, 0, 1, 0, 0, 0, 0, 0, 4'd3, 0);
`ifdef VEND_CANCEL_EN
        add(2'b00, 1, 1, 0, 0, 0, 1, 0, 4'd0, 1);
        add(2'b00, 0, 1, 0, 0, 1, 0, 0, 4'd0, 1);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
        // cancel wins over reaching price: 1 + 5 refunded as 4,2
        add(2'b01, 0, 1, 0, 0, 0, 0, 0, 4'd1, 0);
        add(2'b11, 1, 1, 0, 0, 0, 0, 1, 4'd0, 1);
        add(2'b00, 0, 1, 0, 0, 0, 1, 0, 4'd0, 1);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
`else
        add(2'b00, 1, 1, 0, 0, 0, 0, 0, 4'd3, 0);
        add(2'b00, 1, 1, 0, 0, 0, 0, 0, 4'd3, 0);
        add(2'b10, 1, 1, 0, 1, 0, 0, 0, 4'd5, 1);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
`endif
        // reset mid-CHANGE with rem 3
        add(2'b01, 0, 1, 0, 0, 0, 0, 0, 4'd1, 0);
        add(2'b10, 0, 1, 0, 0, 0, 0, 0, 4'd3, 0);
        add(2'b11, 0, 1, 0, 1, 0, 0, 0, 4'd8, 1);
        add(2'b00, 0, 1, 0, 0, 0, 1, 0, 4'd0, 1);
        add(2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);
        add(2'b00, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0);

        run_table();
        check("scoreboard_empty", 0, 8'(exp_q.size()), 8'd0);

        // Single 5-ruble coin: vend exactly once, one cycle after the coin edge, no change.
        @(negedge CLK); coin = 2'b11;
        @(negedge CLK); coin = 2'b00;
        check("vend_latency", 0, {7'd0, vend}, 8'd1);
        vend_cnt = 0; give_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (vend) vend_cnt++;
            if (give_1_ruble_back || give_2_rubles_back || give_4_rubles_back) give_cnt++;
            @(negedge CLK);
        end
        check("vend_pulse_count", 0, 8'(vend_cnt), 8'd1);
        check("give_count_exact", 0, 8'(give_cnt), 8'd0);
        $display("seq exact5: vend_cnt=%0d give_cnt=%0d", vend_cnt, give_cnt);

        // 2 then 5: wait (bounded) for change to finish, expect exactly one give_2 cycle.
        coin = 2'b10;
        @(negedge CLK); coin = 2'b11;
        @(negedge CLK); coin = 2'b00;
        g2_cnt = 0; cyc = 0;
        while (busy && cyc < 10) begin
            if (give_2_rubles_back) g2_cnt++;
            @(negedge CLK);
            cyc++;
        end
        check("change_done_in_time", 0, {7'd0, (cyc < 10)}, 8'd1);
        check("give2_count", 0, 8'(g2_cnt), 8'd1);
        check("idle_after_change", 0, {3'd0, busy, summ}, 8'd0);
        $display("seq 2+5: give2_cnt=%0d cycles=%0d", g2_cnt, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
